// File: rtl/mem_lsu.sv
// Memory-access stage: aligns/extends loads, replicates store data, runs a req/ack bus transaction.
// Latency: non-memory ops 0 cycles; memory ops take IDLE + BUS(>=1) + DONE, so 3 cycles minimum.
// Backpressure: stallreq_o holds upstream through IDLE-accept and BUS; a bus timeout aborts the access.
module mem_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_sel_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ack_i
);

    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;
    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;
    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t      state, state_nx;
    size_t       sz;
    logic        is_load, is_store, is_mem, sgn, misal;
    logic [1:0]  off;
    logic [3:0]  sel_d;
    logic [31:0] sdata_d;
    logic [7:0]  cnt, cnt_inc;
    logic        to_hit;
    logic [31:0] rdata_q;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ldata;

    assign off     = mem_addr_i[1:0];
    assign wd_o    = wd_i;
    assign is_mem  = is_load | is_store;
    assign cnt_inc = cnt + 8'd1;
    assign to_hit  = (cnt_inc == TO_CNT);

    // Decode the op code into direction, access size and signedness.
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sz       = SZ_B;
        sgn      = 1'b0;
        case (aluop_i)
            OP_LB:   begin is_load = 1'b1;  sz = SZ_B; sgn = 1'b1; end
            OP_LH:   begin is_load = 1'b1;  sz = SZ_H; sgn = 1'b1; end
            OP_LW:   begin is_load = 1'b1;  sz = SZ_W; end
            OP_LBU:  begin is_load = 1'b1;  sz = SZ_B; end
            OP_LHU:  begin is_load = 1'b1;  sz = SZ_H; end
            OP_SB:   begin is_store = 1'b1; sz = SZ_B; end
            OP_SH:   begin is_store = 1'b1; sz = SZ_H; end
            OP_SW:   begin is_store = 1'b1; sz = SZ_W; end
            default: ;
        endcase
        misal = ((sz == SZ_H) && off[0]) || ((sz == SZ_W) && (off != 2'b00));
    end

    // Big-endian lane select and store-data replication for the access about to be issued.
    always_comb begin
        sel_d   = 4'b1111;
        sdata_d = reg2_i;
        case (sz)
            SZ_B: begin
                sel_d   = 4'b1000 >> off;
                sdata_d = {4{reg2_i[7:0]}};
            end
            SZ_H: begin
                sel_d   = off[1] ? 4'b0011 : 4'b1100;
                sdata_d = {2{reg2_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Pick the addressed lane out of the latched bus word and extend it.
    always_comb begin
        ld_b  = rdata_q[{~off, 3'b000} +: 8];
        ld_h  = off[1] ? rdata_q[15:0] : rdata_q[31:16];
        ldata = rdata_q;
        case (sz)
            SZ_B:    ldata = sgn ? {{24{ld_b[7]}}, ld_b} : {24'd0, ld_b};
            SZ_H:    ldata = sgn ? {{16{ld_h[15]}}, ld_h} : {16'd0, ld_h};
            default: ;
        endcase
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Bus-side registers: captured on accept, held through BUS, cleared on ack/timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_sel_o  <= 4'd0;
            mem_addr_o <= 32'd0;
            mem_data_o <= 32'd0;
            bus_err_o  <= 1'b0;
            cnt        <= 8'd0;
            rdata_q    <= 32'd0;
        end else begin
            bus_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (is_mem && !misal) begin
                        mem_req_o  <= 1'b1;
                        mem_we_o   <= is_store;
                        mem_sel_o  <= sel_d;
                        mem_addr_o <= {mem_addr_i[31:2], 2'b00};
                        mem_data_o <= sdata_d;
                        cnt        <= 8'd0;
                    end
                end
                BUS: begin
                    if (mem_ack_i) begin
                        rdata_q   <= mem_data_i;
                        mem_req_o <= 1'b0;
                    end else if (to_hit) begin
                        mem_req_o <= 1'b0;
                        bus_err_o <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state and write-back/stall outputs; bus_err_o doubles as the error mark in DONE.
    always_comb begin
        state_nx   = state;
        wreg_o     = 1'b0;
        wdata_o    = 32'd0;
        stallreq_o = 1'b0;
        misalign_o = 1'b0;
        case (state)
            IDLE: begin
                if (!is_mem) begin
                    wreg_o  = wreg_i;
                    wdata_o = wdata_i;
                end else if (misal) begin
                    misalign_o = 1'b1;
                end else begin
                    stallreq_o = 1'b1;
                    state_nx   = BUS;
                end
            end
            BUS: begin
                stallreq_o = 1'b1;
                if (mem_ack_i || to_hit) state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
                if (is_load && !bus_err_o) begin
                    wreg_o  = wreg_i;
                    wdata_o = ldata;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed vector table, reset corner sequence, then randomized transactions
// scored against a per-transaction reference model. Runs with TIMEOUT = 4.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_mem_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i, reg2_i, wdata_i, mem_data_i;
    logic [4:0]  wd_i, wd_o;
    logic        wreg_i, mem_ack_i;
    logic        wreg_o, stallreq_o, misalign_o, bus_err_o, mem_req_o, mem_we_o;
    logic [31:0] wdata_o, mem_addr_o, mem_data_o;
    logic [3:0]  mem_sel_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_lsu #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i),
        .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_sel_o(mem_sel_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    // One transaction: inputs plus expected results. wt = BUS cycles before ack (>= TO: no ack).
    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [31:0] rdat;
        logic        wreg;
        logic [31:0] wdat;
        int          wt;
        logic [3:0]  e_sel;
        logic [31:0] e_dat;
        logic        e_wreg;
        logic [31:0] e_wdata;
        logic        e_mis;
        logic        e_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic is_store_op(logic [7:0] op);
        return (op == 8'hE8) || (op == 8'hE9) || (op == 8'hEB);
    endfunction

    // Reference model: access width in bytes, alignment by modulo, lanes by byte arithmetic.
    function automatic vec_t model(vec_t v);
        vec_t        r;
        int          size;
        int          o;
        logic        sgn;
        logic        st;
        logic [7:0]  b;
        logic [15:0] h;
        r = v;
        size = 0; sgn = 1'b0; st = 1'b0;
        case (v.op)
            8'hE0: begin size = 1; sgn = 1'b1; end
            8'hE1: begin size = 2; sgn = 1'b1; end
            8'hE3: size = 4;
            8'hE4: size = 1;
            8'hE5: size = 2;
            8'hE8: begin size = 1; st = 1'b1; end
            8'hE9: begin size = 2; st = 1'b1; end
            8'hEB: begin size = 4; st = 1'b1; end
            default: size = 0;
        endcase
        r.e_sel = 4'h0; r.e_dat = 32'h0; r.e_mis = 1'b0; r.e_err = 1'b0;
        r.e_wreg = 1'b0; r.e_wdata = 32'h0;
        o = int'(v.addr[1:0]);
        if (size == 0) begin
            r.e_wreg  = v.wreg;
            r.e_wdata = v.wdat;
        end else if ((o % size) != 0) begin
            r.e_mis = 1'b1;
        end else begin
            r.e_err = (v.wt >= TO);
            if (size == 1) begin
                r.e_sel = 4'(1 << (3 - o));
                r.e_dat = {24'h0, v.reg2[7:0]} * 32'h01010101;
            end else if (size == 2) begin
                r.e_sel = (o < 2) ? 4'hC : 4'h3;
                r.e_dat = {16'h0, v.reg2[15:0]} * 32'h00010001;
            end else begin
                r.e_sel = 4'hF;
                r.e_dat = v.reg2;
            end
            if (!st && !r.e_err) begin
                r.e_wreg = v.wreg;
                b = 8'(v.rdat >> (8 * (3 - o)));
                h = 16'(v.rdat >> ((o < 2) ? 16 : 0));
                if (size == 1)      r.e_wdata = sgn ? {{24{b[7]}}, b} : {24'h0, b};
                else if (size == 2) r.e_wdata = sgn ? {{16{h[15]}}, h} : {16'h0, h};
                else                r.e_wdata = v.rdat;
            end
        end
        return r;
    endfunction

    // Apply one transaction starting 1 unit after a rising edge; ends at the same phase.
    task automatic run_txn(input vec_t v);
        logic [4:0] wd;
        logic       st;
        int         nreq;
        bit         got;
        wd = 5'($urandom);
        st = is_store_op(v.op);
        aluop_i = v.op; mem_addr_i = v.addr; reg2_i = v.reg2; wd_i = wd;
        wreg_i = v.wreg; wdata_i = v.wdat; mem_data_i = $urandom;
        mem_ack_i = 1'($urandom);           // ack outside BUS must be ignored
        @(negedge clk);
        chk("wd_o", {27'h0, wd_o}, {27'h0, wd});
        chk("idle bus_err", {31'h0, bus_err_o}, 32'h0);
        chk("idle req", {31'h0, mem_req_o}, 32'h0);
        chk("idle misalign", {31'h0, misalign_o}, {31'h0, v.e_mis});
        if (v.e_sel == 4'h0) begin
            chk("idle wreg", {31'h0, wreg_o}, {31'h0, v.e_wreg});
            chk("idle wdata", wdata_o, v.e_wdata);
            chk("idle stall", {31'h0, stallreq_o}, 32'h0);
            @(posedge clk); #1;
            mem_ack_i = 1'b0;
            return;
        end
        chk("accept stall", {31'h0, stallreq_o}, 32'h1);
        chk("accept wreg", {31'h0, wreg_o}, 32'h0);
        nreq = 0;
        got  = 1'b0;
        for (int j = 1; j <= TO && !got; j++) begin
            @(posedge clk); #1;
            mem_ack_i  = (j == v.wt + 1);
            mem_data_i = mem_ack_i ? v.rdat : $urandom;
            @(negedge clk);
            chk("bus req", {31'h0, mem_req_o}, 32'h1);
            chk("bus stall", {31'h0, stallreq_o}, 32'h1);
            chk("bus err", {31'h0, bus_err_o}, 32'h0);
            chk("bus addr", mem_addr_o, {v.addr[31:2], 2'b00});
            chk("bus sel", {28'h0, mem_sel_o}, {28'h0, v.e_sel});
            chk("bus we", {31'h0, mem_we_o}, {31'h0, st});
            if (st) chk("bus data", mem_data_o, v.e_dat);
            nreq++;
            got = mem_ack_i;
        end
        @(posedge clk); #1;
        mem_ack_i  = 1'($urandom);
        mem_data_i = $urandom;
        @(negedge clk);
        chk("req cycles", nreq, v.e_err ? TO : v.wt + 1);
        chk("done req", {31'h0, mem_req_o}, 32'h0);
        chk("done stall", {31'h0, stallreq_o}, 32'h0);
        chk("done bus_err", {31'h0, bus_err_o}, {31'h0, v.e_err});
        chk("done wreg", {31'h0, wreg_o}, {31'h0, v.e_wreg});
        chk("done wdata", wdata_o, v.e_wdata);
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
    endtask

    vec_t tbl[14];
    vec_t rv;
    logic [7:0] ops[9];

    initial begin
        //          op     addr          reg2          rdat          wreg  wdat          wt  sel    dat           ewreg ewdata       mis   err
        tbl[0]  = '{8'h25, 32'h0,        32'h0,        32'h0,        1'b1, 32'h1234,     0, 4'h0, 32'h0,        1'b1, 32'h1234,     1'b0, 1'b0};
        tbl[1]  = '{8'hE0, 32'h103,      32'h0,        32'h80,       1'b1, 32'hDEAD,     0, 4'h1, 32'h0,        1'b1, 32'hFFFFFF80, 1'b0, 1'b0};
        tbl[2]  = '{8'hE9, 32'h202,      32'hABCD1234, 32'h0,        1'b1, 32'h0,        3, 4'h3, 32'h12341234, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[3]  = '{8'hE3, 32'h101,      32'h0,        32'h0,        1'b1, 32'h0,        0, 4'h0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0};
        tbl[4]  = '{8'hE3, 32'h100,      32'h0,        32'h11111111, 1'b1, 32'h0,        9, 4'hF, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1};
        tbl[5]  = '{8'hE4, 32'h100,      32'h0,        32'h8A000000, 1'b1, 32'h0,        0, 4'h8, 32'h0,        1'b1, 32'h0000008A, 1'b0, 1'b0};
        tbl[6]  = '{8'hE5, 32'h102,      32'h0,        32'h1234F00D, 1'b1, 32'h0,        1, 4'h3, 32'h0,        1'b1, 32'h0000F00D, 1'b0, 1'b0};
        tbl[7]  = '{8'hE1, 32'h100,      32'h0,        32'h80010000, 1'b1, 32'h0,        2, 4'hC, 32'h0,        1'b1, 32'hFFFF8001, 1'b0, 1'b0};
        tbl[8]  = '{8'hE8, 32'h101,      32'h1234565A, 32'h0,        1'b1, 32'h0,        0, 4'h4, 32'h5A5A5A5A, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[9]  = '{8'hEB, 32'h300,      32'hDEADBEEF, 32'h0,        1'b1, 32'h0,        1, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[10] = '{8'hE3, 32'h104,      32'h0,        32'hCAFEF00D, 1'b1, 32'h0,        3, 4'hF, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0, 1'b0};
        tbl[11] = '{8'hE9, 32'h203,      32'h5555,     32'h0,        1'b1, 32'h0,        0, 4'h0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0};
        tbl[12] = '{8'h00, 32'h0,        32'h0,        32'h0,        1'b0, 32'h55,       0, 4'h0, 32'h0,        1'b0, 32'h55,       1'b0, 1'b0};
        tbl[13] = '{8'hE0, 32'h100,      32'h0,        32'h7F000000, 1'b0, 32'h0,        0, 4'h8, 32'h0,        1'b0, 32'h0000007F, 1'b0, 1'b0};
        ops = '{8'hE0, 8'hE1, 8'hE3, 8'hE4, 8'hE5, 8'hE8, 8'hE9, 8'hEB, 8'h25};

        // Reset state
        rst = 1'b0; aluop_i = 8'h25; mem_addr_i = 32'h0; reg2_i = 32'h0; wd_i = 5'd3;
        wreg_i = 1'b1; wdata_i = 32'h77; mem_data_i = 32'h0; mem_ack_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst req", {31'h0, mem_req_o}, 32'h0);
        chk("rst we", {31'h0, mem_we_o}, 32'h0);
        chk("rst sel", {28'h0, mem_sel_o}, 32'h0);
        chk("rst addr", mem_addr_o, 32'h0);
        chk("rst data", mem_data_o, 32'h0);
        chk("rst bus_err", {31'h0, bus_err_o}, 32'h0);
        chk("rst stall", {31'h0, stallreq_o}, 32'h0);
        chk("rst wdata", wdata_o, 32'h77);
        @(posedge clk); #1;
        rst = 1'b1;

        // Directed table
        for (int i = 0; i < 14; i++) run_txn(tbl[i]);

        // Reset in the middle of BUS, then a late ack
        aluop_i = 8'hE3; mem_addr_i = 32'h400; wreg_i = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid req", {31'h0, mem_req_o}, 32'h1);
        #2;
        rst = 1'b0; aluop_i = 8'h25; wdata_i = 32'h99;
        #1;
        chk("arst req", {31'h0, mem_req_o}, 32'h0);
        chk("arst stall", {31'h0, stallreq_o}, 32'h0);
        chk("arst addr", mem_addr_o, 32'h0);
        chk("arst sel", {28'h0, mem_sel_o}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1; mem_ack_i = 1'b1;
        @(negedge clk);
        chk("late ack req", {31'h0, mem_req_o}, 32'h0);
        chk("late ack wdata", wdata_o, 32'h99);
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        @(negedge clk);
        chk("post ack req", {31'h0, mem_req_o}, 32'h0);
        chk("post ack err", {31'h0, bus_err_o}, 32'h0);
        chk("post ack stall", {31'h0, stallreq_o}, 32'h0);
        chk("post ack wreg", {31'h0, wreg_o}, 32'h1);
        @(posedge clk); #1;

        // Randomized transactions against the model
        for (int n = 0; n < 200; n++) begin
            int k;
            k = $urandom_range(0, 9);
            rv = tbl[0];
            rv.op   = (k == 9) ? 8'($urandom) : ops[k];
            rv.addr = $urandom;
            if ($urandom_range(0, 2) != 0) rv.addr[1:0] = (k == 2 || k == 7) ? 2'b00 : {1'($urandom), 1'b0};
            rv.reg2 = $urandom;
            rv.rdat = $urandom;
            rv.wreg = 1'($urandom);
            rv.wdat = $urandom;
            rv.wt   = $urandom_range(0, 5);
            run_txn(model(rv));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
